// File: rtl/spi_host_bridge.sv
// Host-side front end for the SPI engine: TX/RX byte FIFOs, config register,
// and a launch/wait/store sequencer with a per-transfer watchdog.
module spi_host_bridge #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] core_cfg,
  output logic       core_cfg_load,
  output logic       core_start,
  output logic [7:0] core_tx,
  input  logic       core_done,
  input  logic [7:0] core_rx,
  output logic       busy,
  output logic       cfg_err,
  output logic       timeout,
  input  logic       err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CFG   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] STORE = 3'd4;

  logic [2:0]    state, state_d;
  logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [PW-1:0] tx_wr_d, tx_rd_d, rx_wr_d, rx_rd_d;
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [WW-1:0] wd, wd_d;
  logic [7:0]    rx_byte, rx_byte_d, rx_data_d;
  logic          tx_empty, rx_full, tx_full_d;
  logic          tx_push, rx_pop, rx_push;
  logic          launch, cfg_take, cfg_rej, tmo_hit;

  assign tx_empty = (tx_wr == tx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign tx_push  = tx_valid & tx_ready;
  assign rx_pop   = rx_valid & rx_ready;

  // Launching pops the TX head on the IDLE->LOAD edge so core_tx is valid with core_start.
  assign tx_wr_d   = tx_wr + PW'(tx_push);
  assign tx_rd_d   = tx_rd + PW'(launch);
  assign rx_wr_d   = rx_wr + PW'(rx_push);
  assign rx_rd_d   = rx_rd + PW'(rx_pop);
  assign tx_full_d = (tx_wr_d[AW] != tx_rd_d[AW]) && (tx_wr_d[AW-1:0] == tx_rd_d[AW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    wd_d      = wd;
    rx_byte_d = rx_byte;
    launch    = 1'b0;
    cfg_take  = 1'b0;
    cfg_rej   = 1'b0;
    tmo_hit   = 1'b0;
    rx_push   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_wr) begin
          if (tx_empty) begin
            cfg_take = 1'b1;
            state_d  = CFG;
          end else begin
            cfg_rej = 1'b1;
          end
        end else if (!tx_empty && !rx_full && !core_cfg[0]) begin
          launch  = 1'b1;
          state_d = LOAD;
        end
      end
      CFG:  state_d = IDLE;
      LOAD: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          rx_byte_d = core_rx;
          state_d   = STORE;
        end else if (wd == WW'(TIMEOUT)) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd + WW'(1);
        end
      end
      STORE: begin
        rx_push = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Config writes while a transfer is in flight are rejected too.
    if (cfg_wr && state != IDLE) cfg_rej = 1'b1;
  end

  // Next RX head: new byte when pushing into the slot being read, else memory; hold when empty.
  always_comb begin
    rx_data_d = rx_data;
    if (rx_wr_d != rx_rd_d) begin
      if (rx_push && rx_rd_d == rx_wr) rx_data_d = rx_byte;
      else                             rx_data_d = rx_mem[rx_rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr         <= '0;
      tx_rd         <= '0;
      rx_wr         <= '0;
      rx_rd         <= '0;
      wd            <= '0;
      rx_byte       <= '0;
      core_cfg      <= 8'h01;
      core_tx       <= '0;
      core_cfg_load <= 1'b0;
      core_start    <= 1'b0;
      cfg_err       <= 1'b0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
      tx_ready      <= 1'b1;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
    end else begin
      tx_wr         <= tx_wr_d;
      tx_rd         <= tx_rd_d;
      rx_wr         <= rx_wr_d;
      rx_rd         <= rx_rd_d;
      wd            <= wd_d;
      rx_byte       <= rx_byte_d;
      if (cfg_take) core_cfg <= cfg_data & 8'hFE;
      if (launch)   core_tx  <= tx_mem[tx_rd[AW-1:0]];
      core_cfg_load <= cfg_take;
      core_start    <= launch;
      cfg_err       <= !err_clr && (cfg_err || cfg_rej);
      timeout       <= !err_clr && (timeout || tmo_hit);
      busy          <= (state_d != IDLE) || (tx_wr_d != tx_rd_d);
      tx_ready      <= !tx_full_d;
      rx_valid      <= (rx_wr_d != rx_rd_d);
      rx_data       <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_spi_host_bridge.sv
// Self-checking bench for spi_host_bridge: engine model plus byte-order reference queues.
module tb_spi_host_bridge;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 1023;
  localparam logic [30:0] RST_VEC = {8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic [7:0] core_cfg;
  logic       core_cfg_load;
  logic       core_start;
  logic [7:0] core_tx;
  logic       core_done = 1'b0;
  logic [7:0] core_rx = 8'h00;
  logic       busy;
  logic       cfg_err;
  logic       timeout;
  logic       err_clr = 1'b0;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] start_log[$];
  logic [7:0] sent[$];
  logic [7:0] exp_rx[$];
  bit         eng_en = 1'b0;
  bit         eng_rand = 1'b0;
  int         eng_delay = 1;
  logic [7:0] eng_key = 8'h00;
  logic [7:0] eb;
  int         ed;
  logic [7:0] cur_cfg;

  spi_host_bridge #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_data(cfg_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .core_cfg(core_cfg), .core_cfg_load(core_cfg_load), .core_start(core_start),
    .core_tx(core_tx), .core_done(core_done), .core_rx(core_rx),
    .busy(busy), .cfg_err(cfg_err), .timeout(timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Engine: answers each start with (tx ^ key) after a delay, checking core_tx stays put.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (core_start) begin
        eb = core_tx;
        start_log.push_back(eb);
        if (eng_en) begin
          ed = eng_rand ? int'($urandom_range(6, 1)) : eng_delay;
          repeat (ed) begin
            @(posedge clk); #1;
            nvec++;
            if (core_tx !== eb) begin nerr++; $display("FAIL core_tx_hold: got %h want %h", core_tx, eb); end
          end
          core_rx = eb ^ eng_key;
          core_done = 1'b1;
          @(posedge clk); #1;
          core_done = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_wr = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    cur_cfg = 8'h01;
  endtask

  task automatic push(input logic [7:0] b, output bit ok);
    ok = 1'b0; tx_valid = 1'b1; tx_data = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (tx_ready) ok = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    nvec++;
    if (!ok) begin nerr++; $display("FAIL push_accept: got no handshake want accept of %h", b); end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (core_start) ok = 1'b1;
      else tick();
    end
    nvec++;
    if (!ok) begin nerr++; $display("FAIL wait_start: got none want core_start within %0d", budget); end
  endtask

  task automatic wait_rx(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (rx_valid) ok = 1'b1;
      else tick();
    end
    nvec++;
    if (!ok) begin nerr++; $display("FAIL wait_rx: got none want rx_valid within %0d", budget); end
  endtask

  task automatic test_reset();
    logic [30:0] rv;
    do_reset();
    rv = {core_cfg, core_cfg_load, core_start, core_tx, tx_ready, rx_valid, rx_data, busy, cfg_err, timeout};
    nvec++;
    if (rv !== RST_VEC) begin nerr++; $display("FAIL reset_vals: got %h want %h", rv, RST_VEC); end
  endtask

  task automatic test_config();
    logic [7:0] r;
    cfg_wr = 1'b1; cfg_data = 8'hB4;
    tick();
    cfg_wr = 1'b0;
    nvec++;
    if ({core_cfg, core_cfg_load, cfg_err} !== {8'hB4, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL cfg_load: got cfg=%h load=%b err=%b want cfg=b4 load=1 err=0", core_cfg, core_cfg_load, cfg_err);
    end
    tick();
    nvec++;
    if (core_cfg_load !== 1'b0) begin nerr++; $display("FAIL cfg_pulse_width: got %b want 0", core_cfg_load); end
    r = 8'($urandom) | 8'h01;
    cfg_wr = 1'b1; cfg_data = r;
    tick();
    cfg_wr = 1'b0;
    cur_cfg = {r[7:1], 1'b0};
    nvec++;
    if ({core_cfg, core_cfg_load} !== {cur_cfg, 1'b1}) begin
      nerr++; $display("FAIL cfg_bit0: got cfg=%h load=%b want cfg=%h load=1", core_cfg, core_cfg_load, cur_cfg);
    end
    tick();
  endtask

  task automatic test_single();
    eng_en = 1'b1; eng_rand = 1'b0; eng_delay = 20; eng_key = 8'h5A ^ 8'hC3;
    tx_valid = 1'b1; tx_data = 8'h5A;
    nvec++;
    if (tx_ready !== 1'b1) begin nerr++; $display("FAIL single_ready: got %b want 1", tx_ready); end
    tick();
    tx_valid = 1'b0;
    nvec++;
    if (core_start !== 1'b0) begin nerr++; $display("FAIL start_early: got %b want 0 at N+1", core_start); end
    tick();
    nvec++;
    if ({core_start, core_tx} !== {1'b1, 8'h5A}) begin
      nerr++; $display("FAIL start_latency: got start=%b tx=%h want start=1 tx=5a at N+2", core_start, core_tx);
    end
    repeat (21) tick();
    nvec++;
    if (rx_valid !== 1'b0) begin nerr++; $display("FAIL rx_early: got %b want 0 at done+1", rx_valid); end
    tick();
    nvec++;
    if ({rx_valid, rx_data, busy} !== {1'b1, 8'hC3, 1'b0}) begin
      nerr++; $display("FAIL rx_latency: got v=%b d=%h busy=%b want v=1 d=c3 busy=0", rx_valid, rx_data, busy);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    nvec++;
    if (rx_valid !== 1'b0) begin nerr++; $display("FAIL rx_pop: got %b want 0", rx_valid); end
  endtask

  task automatic test_rx_backpressure();
    bit ok;
    logic [7:0] b;
    eng_en = 1'b1; eng_rand = 1'b1; eng_key = 8'($urandom);
    start_log.delete(); sent.delete(); exp_rx.delete();
    for (int i = 0; i < int'(DEPTH); i++) begin
      b = 8'($urandom);
      push(b, ok);
      sent.push_back(b);
      exp_rx.push_back(b ^ eng_key);
    end
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      if (start_log.size() == int'(DEPTH) && !busy) ok = 1'b1;
      else tick();
    end
    nvec++;
    if (!ok) begin nerr++; $display("FAIL rxfull_settle: got %0d starts want %0d", start_log.size(), DEPTH); end
    nvec++;
    if ({rx_valid, rx_data} !== {1'b1, exp_rx[0]}) begin
      nerr++; $display("FAIL rxfull_head: got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, exp_rx[0]);
    end
  endtask

  task automatic test_tx_full();
    bit ok;
    logic [7:0] b;
    logic [7:0] acc[$];
    for (int i = 0; i < int'(DEPTH); i++) begin
      b = 8'($urandom);
      push(b, ok);
      acc.push_back(b);
      nvec++;
      if (tx_ready !== (i < int'(DEPTH) - 1)) begin
        nerr++; $display("FAIL tx_ready_fill%0d: got %b want %b", i, tx_ready, (i < int'(DEPTH) - 1));
      end
    end
    tx_valid = 1'b1; tx_data = 8'($urandom);
    repeat (5) tick();
    tx_valid = 1'b0;
    repeat (10) tick();
    nvec++;
    if ({tx_ready, 32'(start_log.size())} !== {1'b0, 32'(DEPTH)}) begin
      nerr++; $display("FAIL full_stall: got ready=%b starts=%0d want ready=0 starts=%0d", tx_ready, start_log.size(), DEPTH);
    end
    foreach (acc[i]) begin
      sent.push_back(acc[i]);
      exp_rx.push_back(acc[i] ^ eng_key);
    end
    nvec++;
    if (rx_data !== exp_rx[0]) begin nerr++; $display("FAIL pop1_data: got %h want %h", rx_data, exp_rx[0]); end
    void'(exp_rx.pop_front());
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    nvec++;
    if (core_start !== 1'b0) begin nerr++; $display("FAIL pop_start_early: got %b want 0", core_start); end
    tick();
    nvec++;
    if ({core_start, core_tx} !== {1'b1, acc[0]}) begin
      nerr++; $display("FAIL pop_restart: got start=%b tx=%h want start=1 tx=%h", core_start, core_tx, acc[0]);
    end
    for (int i = 0; i < 3000 && exp_rx.size() > 0; i++) begin
      if (rx_valid) begin
        nvec++;
        if (rx_data !== exp_rx[0]) begin nerr++; $display("FAIL drain_data: got %h want %h", rx_data, exp_rx[0]); end
        void'(exp_rx.pop_front());
        rx_ready = 1'b1;
      end else begin
        rx_ready = 1'b0;
      end
      tick();
    end
    rx_ready = 1'b0;
    nvec++;
    if (exp_rx.size() != 0) begin nerr++; $display("FAIL drain_count: got %0d left want 0", exp_rx.size()); end
    nvec++;
    if (start_log.size() != sent.size()) begin
      nerr++; $display("FAIL start_count: got %0d want %0d", start_log.size(), sent.size());
    end
    for (int i = 0; i < sent.size() && i < start_log.size(); i++) begin
      nvec++;
      if (start_log[i] !== sent[i]) begin nerr++; $display("FAIL start_order%0d: got %h want %h", i, start_log[i], sent[i]); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] b;
    eng_en = 1'b0;
    push(8'($urandom), ok);
    wait_start(10, ok);
    repeat (TIMEOUT + 1) tick();
    nvec++;
    if ({timeout, busy} !== 2'b01) begin nerr++; $display("FAIL tmo_early: got t=%b busy=%b want t=0 busy=1", timeout, busy); end
    tick();
    nvec++;
    if ({timeout, busy, rx_valid} !== 3'b100) begin
      nerr++; $display("FAIL tmo_set: got t=%b busy=%b rxv=%b want t=1 busy=0 rxv=0", timeout, busy, rx_valid);
    end
    eng_en = 1'b1; eng_rand = 1'b0; eng_delay = 3; eng_key = 8'($urandom);
    b = 8'($urandom);
    push(b, ok);
    wait_start(10, ok);
    nvec++;
    if (core_tx !== b) begin nerr++; $display("FAIL tmo_relaunch: got %h want %h", core_tx, b); end
    wait_rx(50, ok);
    nvec++;
    if ({rx_data, timeout} !== {b ^ eng_key, 1'b1}) begin
      nerr++; $display("FAIL tmo_recover: got d=%h t=%b want d=%h t=1", rx_data, timeout, b ^ eng_key);
    end
    rx_ready = 1'b1; err_clr = 1'b1;
    tick();
    rx_ready = 1'b0; err_clr = 1'b0;
    nvec++;
    if (timeout !== 1'b0) begin nerr++; $display("FAIL tmo_clear: got %b want 0", timeout); end
    eng_en = 1'b0;
    push(8'($urandom), ok);
    wait_start(10, ok);
    repeat (TIMEOUT + 1) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    nvec++;
    if ({timeout, busy} !== 2'b00) begin nerr++; $display("FAIL clr_wins: got t=%b busy=%b want t=0 busy=0", timeout, busy); end
  endtask

  task automatic test_cfg_reject_and_reset();
    bit ok;
    bit seen;
    logic [30:0] rv;
    eng_en = 1'b0;
    push(8'($urandom), ok);
    wait_start(10, ok);
    tick(); tick();
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    rv = {core_cfg, core_cfg_load, core_start, core_tx, tx_ready, rx_valid, rx_data, busy, cfg_err, timeout};
    nvec++;
    if (rv !== RST_VEC) begin nerr++; $display("FAIL async_reset: got %h want %h", rv, RST_VEC); end
    tick();
    rst = 1'b0;
    tick();
    rv = {core_cfg, core_cfg_load, core_start, core_tx, tx_ready, rx_valid, rx_data, busy, cfg_err, timeout};
    nvec++;
    if (rv !== RST_VEC) begin nerr++; $display("FAIL post_reset: got %h want %h", rv, RST_VEC); end
    push(8'($urandom), ok);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= core_start;
      tick();
    end
    nvec++;
    if ({seen, busy} !== 2'b01) begin nerr++; $display("FAIL no_cfg_launch: got start=%b busy=%b want start=0 busy=1", seen, busy); end
    cfg_wr = 1'b1; cfg_data = 8'h3C;
    tick();
    cfg_wr = 1'b0;
    nvec++;
    if ({cfg_err, core_cfg, core_cfg_load} !== {1'b1, 8'h01, 1'b0}) begin
      nerr++; $display("FAIL cfg_reject: got err=%b cfg=%h load=%b want err=1 cfg=01 load=0", cfg_err, core_cfg, core_cfg_load);
    end
    cfg_wr = 1'b1; err_clr = 1'b1;
    tick();
    cfg_wr = 1'b0; err_clr = 1'b0;
    nvec++;
    if (cfg_err !== 1'b0) begin nerr++; $display("FAIL cfg_clr_wins: got %b want 0", cfg_err); end
    do_reset();
  endtask

  task automatic test_random();
    bit ok;
    int got;
    logic [7:0] r;
    start_log.delete(); sent.delete(); exp_rx.delete();
    r = 8'($urandom) & 8'hFE;
    cfg_wr = 1'b1; cfg_data = r;
    tick();
    cfg_wr = 1'b0;
    tick();
    eng_en = 1'b1; eng_rand = 1'b1; eng_key = 8'($urandom);
    got = 0;
    fork
      begin
        logic [7:0] b;
        bit pok;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(3, 0)) tick();
          b = 8'($urandom);
          push(b, pok);
          sent.push_back(b);
          exp_rx.push_back(b ^ eng_key);
        end
      end
      begin
        bit take;
        for (int i = 0; i < 4000 && got < 40; i++) begin
          take = 1'($urandom_range(1, 0));
          rx_ready = take;
          if (rx_valid && take) begin
            nvec++;
            if (exp_rx.size() == 0) begin
              nerr++; $display("FAIL rand_extra: got %h want nothing", rx_data);
            end else begin
              if (rx_data !== exp_rx[0]) begin nerr++; $display("FAIL rand_data%0d: got %h want %h", got, rx_data, exp_rx[0]); end
              void'(exp_rx.pop_front());
            end
            got++;
          end
          tick();
        end
        rx_ready = 1'b0;
      end
    join
    nvec++;
    if (got != 40) begin nerr++; $display("FAIL rand_count: got %0d want 40", got); end
    for (int i = 0; i < sent.size(); i++) begin
      nvec++;
      if (i >= start_log.size() || start_log[i] !== sent[i]) begin
        nerr++; $display("FAIL rand_order%0d: want %h", i, sent[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_single();
    test_rx_backpressure();
    test_tx_full();
    test_timeout();
    test_cfg_reject_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
